move_sequencer: RTL and testbench

- Initiator and owner of the board state for move validation.
- Accepts square selections from the cursor/input layer and builds an (old, new) move request for the board validator.
- Holds the request stable through the validator's one-cycle delta pipeline, then samples the validity result.
- On a legal move, commits the validator's updated board into the master board register and passes the turn.

---
 rtl/chess_pkg.sv | 63 ++++++
 rtl/move_sequencer_if.sv | 34 +++
 rtl/move_sequencer.sv | 179 +++++++++++++++++
 tb/tb_move_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess types: piece codes, board layout, sequencer states, ownership helper.
package chess_pkg;

  localparam int unsigned COORD_W  = 3;
  localparam int unsigned PIECE_W  = 4;
  localparam int unsigned VAL_LAT  = 1;
  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned CNT_W    = 3;

  localparam logic [PIECE_W-1:0] W_ROOK   = 4'd0;
  localparam logic [PIECE_W-1:0] W_KNIGHT = 4'd1;
  localparam logic [PIECE_W-1:0] W_BISHOP = 4'd2;
  localparam logic [PIECE_W-1:0] W_QUEEN  = 4'd3;
  localparam logic [PIECE_W-1:0] W_KING   = 4'd4;
  localparam logic [PIECE_W-1:0] W_PAWN   = 4'd5;
  localparam logic [PIECE_W-1:0] B_ROOK   = 4'd6;
  localparam logic [PIECE_W-1:0] B_PAWN   = 4'd11;
  localparam logic [PIECE_W-1:0] PIECE_EMPTY = 4'd15;

  // Board indexed [y][x], one 4-bit piece code per square
  typedef logic [7:0][7:0][PIECE_W-1:0] board_t;

  typedef enum logic [2:0] {IDLE, WAIT_DST, REQ, CHECK, COMMIT, REJECT} state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_WHITE, OWN_BLACK} owner_t;

  // Side owning a piece code; codes 12..15 belong to nobody
  function automatic owner_t piece_owner(input logic [PIECE_W-1:0] code);
    if (code <= W_PAWN) return OWN_WHITE;
    else if (code <= B_PAWN) return OWN_BLACK;
    else return OWN_NONE;
  endfunction

  // White back-rank piece for file x; black uses the same layout offset by B_ROOK
  function automatic logic [PIECE_W-1:0] back_rank(input int unsigned x);
    case (x)
      0, 7:    return W_ROOK;
      1, 6:    return W_KNIGHT;
      2, 5:    return W_BISHOP;
      3:       return W_QUEEN;
      default: return W_KING;
    endcase
  endfunction

  function automatic board_t init_board();
    board_t b;
    for (int unsigned y = 0; y < 8; y++) begin
      for (int unsigned x = 0; x < 8; x++) begin
        b[3'(y)][3'(x)] = PIECE_EMPTY;
      end
    end
    for (int unsigned x = 0; x < 8; x++) begin
      b[3'd0][3'(x)] = back_rank(x) + B_ROOK;
      b[3'd1][3'(x)] = B_PAWN;
      b[3'd6][3'(x)] = W_PAWN;
      b[3'd7][3'(x)] = back_rank(x);
    end
    return b;
  endfunction

  localparam board_t INIT_BOARD = init_board();

endpackage

// File: rtl/move_sequencer_if.sv
// Selection, validator and board-state signals of the move sequencer.
interface move_sequencer_if;
  import chess_pkg::*;

  logic               sel_valid;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic               undo_req;
  logic [COORD_W-1:0] old_x;
  logic [COORD_W-1:0] old_y;
  logic [COORD_W-1:0] new_x;
  logic [COORD_W-1:0] new_y;
  logic [PIECE_W-1:0] piece_type;
  board_t             val_board;
  logic               val_valid;
  board_t             board_q;
  logic               turn;
  logic               busy;
  logic               move_done;
  logic               move_reject;
  logic               src_lit;

  modport slave (
    input  sel_valid, sel_x, sel_y, undo_req, val_board, val_valid,
    output old_x, old_y, new_x, new_y, piece_type, board_q, turn,
           busy, move_done, move_reject, src_lit
  );

  modport master (
    output sel_valid, sel_x, sel_y, undo_req, val_board, val_valid,
    input  old_x, old_y, new_x, new_y, piece_type, board_q, turn,
           busy, move_done, move_reject, src_lit
  );
endinterface

// File: rtl/move_sequencer.sv
// Builds (old,new) move requests from square selections, waits for the validator
// verdict and commits the validated board. Optional undo: define MOVE_UNDO_EN.
module move_sequencer
  import chess_pkg::*;
(
  input  logic            CLOCK_50,
  input  logic            reset,
  move_sequencer_if.slave bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] old_x_q, old_x_d, old_y_q, old_y_d;
  logic [COORD_W-1:0] new_x_q, new_x_d, new_y_q, new_y_d;
  logic [PIECE_W-1:0] piece_q, piece_d;
  board_t             board_q, board_d;
  logic               turn_q, turn_d;
  logic               busy_q, busy_d;
  logic               src_lit_q, src_lit_d;
  logic               done_q, done_d;
  logic               reject_q, reject_d;

  logic [PIECE_W-1:0] sel_piece;
  logic               sel_own;
  logic               sel_is_src;

`ifdef MOVE_UNDO_EN
  board_t             undo_board_q, undo_board_d;
  logic               undo_turn_q, undo_turn_d;
  logic               undo_avail_q, undo_avail_d;
`else
  logic               unused_undo;
  assign unused_undo = bus.undo_req;
`endif

  assign sel_piece  = board_q[bus.sel_y][bus.sel_x];
  assign sel_own    = piece_owner(sel_piece) == (turn_q ? OWN_BLACK : OWN_WHITE);
  assign sel_is_src = (bus.sel_x == old_x_q) && (bus.sel_y == old_y_q);

  // Next-state and next register values; selections outside IDLE/WAIT_DST are dropped
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    old_x_d  = old_x_q;
    old_y_d  = old_y_q;
    new_x_d  = new_x_q;
    new_y_d  = new_y_q;
    piece_d  = piece_q;
    board_d  = board_q;
    turn_d   = turn_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
`ifdef MOVE_UNDO_EN
    undo_board_d = undo_board_q;
    undo_turn_d  = undo_turn_q;
    undo_avail_d = undo_avail_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MOVE_UNDO_EN
        if (bus.undo_req && undo_avail_q) begin
          board_d      = undo_board_q;
          turn_d       = undo_turn_q;
          undo_avail_d = 1'b0;
          done_d       = 1'b1;
        end else
`endif
        if (bus.sel_valid && sel_own) begin
          old_x_d = bus.sel_x;
          old_y_d = bus.sel_y;
          piece_d = sel_piece;
          state_d = WAIT_DST;
        end
      end
      WAIT_DST: begin
        if (bus.sel_valid) begin
          if (sel_is_src) begin
            state_d = IDLE;
          end else if (sel_own) begin
            old_x_d = bus.sel_x;
            old_y_d = bus.sel_y;
            piece_d = sel_piece;
          end else begin
            new_x_d = bus.sel_x;
            new_y_d = bus.sel_y;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VAL_LAT)) begin
          if (bus.val_valid) begin
            board_d = bus.val_board;
            turn_d  = ~turn_q;
            done_d  = 1'b1;
            state_d = COMMIT;
`ifdef MOVE_UNDO_EN
            undo_board_d = board_q;
            undo_turn_d  = turn_q;
            undo_avail_d = 1'b1;
`endif
          end else begin
            reject_d = 1'b1;
            state_d  = REJECT;
          end
        end else if (cnt_d >= CNT_W'(WAIT_MAX)) begin
          reject_d = 1'b1;
          state_d  = REJECT;
        end
      end
      COMMIT:  state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d == REQ) || (state_d == CHECK);
    src_lit_d = (state_d == WAIT_DST);
  end

  // State and datapath registers; reset restores the opening position
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      old_x_q   <= '0;
      old_y_q   <= '0;
      new_x_q   <= '0;
      new_y_q   <= '0;
      piece_q   <= PIECE_EMPTY;
      board_q   <= INIT_BOARD;
      turn_q    <= 1'b0;
      busy_q    <= 1'b0;
      src_lit_q <= 1'b0;
      done_q    <= 1'b0;
      reject_q  <= 1'b0;
`ifdef MOVE_UNDO_EN
      undo_board_q <= INIT_BOARD;
      undo_turn_q  <= 1'b0;
      undo_avail_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      old_x_q   <= old_x_d;
      old_y_q   <= old_y_d;
      new_x_q   <= new_x_d;
      new_y_q   <= new_y_d;
      piece_q   <= piece_d;
      board_q   <= board_d;
      turn_q    <= turn_d;
      busy_q    <= busy_d;
      src_lit_q <= src_lit_d;
      done_q    <= done_d;
      reject_q  <= reject_d;
`ifdef MOVE_UNDO_EN
      undo_board_q <= undo_board_d;
      undo_turn_q  <= undo_turn_d;
      undo_avail_q <= undo_avail_d;
`endif
    end
  end

  assign bus.old_x       = old_x_q;
  assign bus.old_y       = old_y_q;
  assign bus.new_x       = new_x_q;
  assign bus.new_y       = new_y_q;
  assign bus.piece_type  = piece_q;
  assign bus.board_q     = board_q;
  assign bus.turn        = turn_q;
  assign bus.busy        = busy_q;
  assign bus.src_lit     = src_lit_q;
  assign bus.move_done   = done_q;
  assign bus.move_reject = reject_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: table of move attempts plus hand-written corner sequences.
module tb_move_sequencer;
  import chess_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_REJ  = 2;

  typedef struct {
    int sx; int sy; int dx; int dy;
    bit vv;
    int kind;
  } vec_t;

  typedef struct {
    int kind;
    int due;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   cyc      = 0;
  int   total    = 0;
  int   bad      = 0;

  exp_t   exp_q[$];
  board_t model;
  int     turn_m;
  vec_t   vecs[6];

  move_sequencer_if bus();

  move_sequencer dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_board(input string name, input board_t got, input board_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic board_t tb_init();
    board_t b;
    int back[8];
    back = '{0, 1, 2, 3, 4, 2, 1, 0};
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) b[3'(y)][3'(x)] = 4'd15;
    for (int x = 0; x < 8; x++) begin
      b[3'd7][3'(x)] = 4'(back[x]);
      b[3'd0][3'(x)] = 4'(back[x] + 6);
      b[3'd6][3'(x)] = 4'd5;
      b[3'd1][3'(x)] = 4'd11;
    end
    return b;
  endfunction

  function automatic board_t apply(input board_t b, input int sx, input int sy,
                                   input int dx, input int dy);
    board_t r;
    r = b;
    r[3'(dy)][3'(dx)] = b[3'(sy)][3'(sx)];
    r[3'(sy)][3'(sx)] = 4'd15;
    return r;
  endfunction

  // Pulse monitor: every move_done/move_reject must match the oldest expectation
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (!reset && (bus.move_done || bus.move_reject)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: done=%0b reject=%0b expected none (cyc %0d)",
                 bus.move_done, bus.move_reject, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", bus.move_done ? K_DONE : K_REJ, e.kind);
        chk("pulse_cycle", cyc, e.due);
      end
    end
  end

  task automatic sel(input int x, input int y, output int t);
    @(negedge CLOCK_50);
    t = cyc;
    bus.sel_valid = 1'b1;
    bus.sel_x     = 3'(x);
    bus.sel_y     = 3'(y);
    @(negedge CLOCK_50);
    bus.sel_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    exp_q.delete();
    model  = tb_init();
    turn_m = 0;
  endtask

  task automatic idle_checks(input string tag);
    repeat (2) @(negedge CLOCK_50);
    chk_board({tag, "_board"}, bus.board_q, model);
    chk({tag, "_turn"}, int'(bus.turn), turn_m);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  // One move attempt: source, destination, verdict; request fields checked in REQ
  task automatic attempt(input vec_t v, input string tag);
    int t;
    board_t nb;
    sel(v.sx, v.sy, t);
    chk({tag, "_src_lit"}, int'(bus.src_lit), 1);
    nb = apply(model, v.sx, v.sy, v.dx, v.dy);
    bus.val_valid = v.vv;
    bus.val_board = nb;
    if (v.kind != K_NONE) exp_q.push_back('{v.kind, t + 4});
    sel(v.dx, v.dy, t);
    if (v.kind != K_NONE) exp_q[exp_q.size() - 1].due = t + 4;
    if (v.kind == K_NONE) begin
      chk({tag, "_cancel_lit"}, int'(bus.src_lit), 0);
    end else begin
      chk({tag, "_req_busy"}, int'(bus.busy), 1);
      chk({tag, "_req_sq"}, int'({bus.old_x, bus.old_y, bus.new_x, bus.new_y}),
          int'({3'(v.sx), 3'(v.sy), 3'(v.dx), 3'(v.dy)}));
      chk({tag, "_req_piece"}, int'(bus.piece_type), int'(model[3'(v.sy)][3'(v.sx)]));
    end
    repeat (4) @(negedge CLOCK_50);
    if (v.kind == K_DONE) begin
      model  = nb;
      turn_m = 1 - turn_m;
    end
    idle_checks(tag);
  endtask

  initial begin
    int t;
    vec_t v;
    bus.sel_valid = 1'b0;
    bus.sel_x     = '0;
    bus.sel_y     = '0;
    bus.undo_req  = 1'b0;
    bus.val_valid = 1'b0;
    bus.val_board = '0;

    vecs[0] = '{4, 6, 4, 4, 1'b1, K_DONE};
    vecs[1] = '{3, 1, 3, 3, 1'b1, K_DONE};
    vecs[2] = '{1, 7, 1, 7, 1'b0, K_NONE};
    vecs[3] = '{0, 6, 0, 3, 1'b0, K_REJ};
    vecs[4] = '{6, 7, 5, 5, 1'b1, K_DONE};
    vecs[5] = '{1, 0, 2, 2, 1'b0, K_REJ};

    do_reset();
    chk_board("rst_board", bus.board_q, model);
    chk("rst_turn", int'(bus.turn), 0);
    chk("rst_piece", int'(bus.piece_type), 15);
    chk("rst_req", int'({bus.old_x, bus.old_y, bus.new_x, bus.new_y}), 0);
    chk("rst_flags", int'({bus.busy, bus.src_lit, bus.move_done, bus.move_reject}), 0);

    for (int i = 0; i < 6; i++) attempt(vecs[i], $sformatf("vec%0d", i));

    // Opponent's piece at turn 0 is ignored
    do_reset();
    sel(0, 1, t);
    chk("opp_src_lit", int'(bus.src_lit), 0);
    idle_checks("opp");

    // Reselect source onto own pawn, then move that pawn
    sel(0, 7, t);
    chk("resel_lit1", int'(bus.src_lit), 1);
    sel(0, 6, t);
    chk("resel_lit2", int'(bus.src_lit), 1);
    chk("resel_busy", int'(bus.busy), 0);
    chk("resel_old", int'({bus.old_x, bus.old_y}), int'({3'd0, 3'd6}));
    v = '{0, 6, 0, 4, 1'b1, K_DONE};
    bus.val_valid = 1'b1;
    bus.val_board = apply(model, 0, 6, 0, 4);
    sel(0, 4, t);
    exp_q.push_back('{K_DONE, t + 4});
    chk("resel_piece", int'(bus.piece_type), 5);
    repeat (4) @(negedge CLOCK_50);
    model  = apply(model, 0, 6, 0, 4);
    turn_m = 1;
    idle_checks("resel");

    // Illegal e2-e5 from the opening position
    do_reset();
    attempt('{4, 6, 4, 3, 1'b0, K_REJ}, "rej");
    chk_board("rej_init", bus.board_q, tb_init());

    // Reset during CHECK abandons the move with no pulse
    do_reset();
    bus.val_valid = 1'b1;
    bus.val_board = apply(model, 4, 6, 4, 4);
    sel(4, 6, t);
    sel(4, 4, t);
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    idle_checks("midrst");
    chk("midrst_flags", int'({bus.src_lit, bus.move_done, bus.move_reject}), 0);

`ifdef MOVE_UNDO_EN
    // Commit e2-e4, undo it, and check a second undo is ignored
    do_reset();
    attempt('{4, 6, 4, 4, 1'b1, K_DONE}, "undo_mv");
    @(negedge CLOCK_50);
    exp_q.push_back('{K_DONE, cyc + 1});
    bus.undo_req = 1'b1;
    @(negedge CLOCK_50);
    bus.undo_req = 1'b0;
    model  = tb_init();
    turn_m = 0;
    idle_checks("undo1");
    @(negedge CLOCK_50);
    bus.undo_req = 1'b1;
    @(negedge CLOCK_50);
    bus.undo_req = 1'b0;
    idle_checks("undo2");
`endif

    repeat (3) @(negedge CLOCK_50);
    chk("final_sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

endmodule
